aline_scheduler: RTL and testbench
==================================

Name: aline_scheduler

Overview:
Sequences one image acquisition across the stored A-lines. Each image is driven as a series of per-A-line steps:
- ask the config store to read that A-line's delays;
- wait for the delay readout to complete;
- issue a transmit fire strobe;
- wait for the acquisition to finish, then hold off for the pulse repetition interval before the next A-line.

The block sits between the host/UART control logic and the config store (rd_en/which_aline/updating_delays handshake) plus the pulse/acquisition front end.

Parameters:
SETTLE_CYCLES, 4, cycles between delay readout completion and fire (delay-register settling).
UPD_TIMEOUT, 32, max cycles to wait for each updating_delays edge.
ACQ_TIMEOUT, 50000, max cycles to wait for acq_done after fire.
PRI_CYCLES, 1000, idle gap after acquisition before next A-line (pulse repetition interval).
CNT_W, 16, width of the shared cycle counter; every timing parameter must fit in CNT_W bits.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
start  in  1  one-cycle request to acquire one image
abort  in  1  level; forces return to IDLE
intaking_configs  in  1  config store is loading new configs
updating_delays  in  1  config store delay-readout busy flag
aline_select  in  5  number of A-lines in the image
channel_select  in  8  enabled transmit channels
acq_done  in  1  one-cycle pulse: acquisition of the current A-line finished
rd_en  out  1  one-cycle delay-read request to the config store
which_aline  out  4  A-line index being read and fired
fire  out  1  one-cycle transmit strobe
fire_channels  out  8  channel_select latched at start; valid while busy
busy  out  1  high from the cycle after start is accepted until return to IDLE
image_done  out  1  one-cycle pulse when all A-lines complete
timeout_err  out  1  sticky error flag; cleared when the next start is accepted

Behaviour:
- Reset (rst==0 at posedge):
  - state IDLE;
  - all outputs 0;
  - counter 0, A-line index 0, latched n_alines 0.
- Registering and priority:
  - All outputs are registered.
  - Single clocked process; state, counter and index update on posedge only.
- IDLE: start is accepted only if intaking_configs==0. On accept:
  - latch n_alines = min(aline_select, 16);
  - latch fire_channels = channel_select;
  - clear timeout_err; which_aline = 0; busy = 1.
  - If n_alines == 0, go to DONE; otherwise go to REQ.
  - start while intaking_configs==1 is dropped. start while busy is ignored.
- REQ: rd_en = 1 for exactly this cycle; counter cleared; go to WAIT_HI.
- WAIT_HI: waits for updating_delays==1, then goes to WAIT_LO with counter cleared. If the counter reaches UPD_TIMEOUT first, go to ERR.
- WAIT_LO: waits for updating_delays==0, then goes to SETTLE with counter cleared. Timeout goes to ERR, as in WAIT_HI.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to FIRE.
- FIRE: fire = 1 for one cycle; counter cleared; go to ACQ.
- ACQ: on acq_done, go to GAP with counter cleared. If the counter reaches ACQ_TIMEOUT, go to ERR.
- GAP: counts PRI_CYCLES cycles, then:
  - if which_aline == n_alines-1, go to DONE;
  - else which_aline += 1 and go to REQ.
- DONE: image_done = 1 for one cycle; busy = 0; which_aline = 0; go to IDLE.
- ERR: timeout_err = 1; busy = 0; which_aline = 0; go to IDLE; no image_done.
- Abort and config-load override:
  - abort==1, or intaking_configs==1, in any non-IDLE state goes to IDLE next cycle.
  - busy drops; no image_done; timeout_err is unchanged.
  - This check has priority over all transitions, including a simultaneous acq_done.
- Edge cases:
  - acq_done outside ACQ is ignored.
  - An A-line index of 15 is the maximum; aline_select 16..31 clamps to 16 A-lines.
  - Counter compares use >= (param-1) so no wrap is possible; the counter saturates.
- Latency: start to first rd_en is 1 cycle; start to first fire is at least 3 + SETTLE_CYCLES + the config-store readout time.

Decomposition:
- Shared package/defines file: state encodings (SCHED_IDLE, SCHED_REQ, SCHED_WAIT_HI, SCHED_WAIT_LO, SCHED_SETTLE, SCHED_FIRE, SCHED_ACQ, SCHED_GAP, SCHED_DONE, SCHED_ERR), 4-bit state width, and the MAX_ALINES=16 constant.
- One natural sub-module: sched_timer, a loadable saturating CNT_W counter with clear and a terminal-count compare, reused for the settle, timeout and PRI waits.

Test Plan:
1. aline_select=3, channel_select=8'hA5, model store raises updating_delays 1 cycle after rd_en for 6 cycles, acq_done 20 cycles after fire -> exactly 3 rd_en and 3 fire; which_aline 0,1,2; fire_channels=8'hA5; one image_done; timeout_err=0.
2. aline_select=0 -> no rd_en, no fire, image_done 2 cycles after start.
3. aline_select=5'd20 -> 16 fires; which_aline ends at 15, then returns to 0.
4. Store never raises updating_delays -> timeout_err=1 at UPD_TIMEOUT+2 cycles after start; busy=0; no fire. The next start clears timeout_err.
5. abort (or intaking_configs) asserted during ACQ of A-line 1 together with acq_done -> IDLE next cycle; no further fire; no image_done.
6. rst=0 asserted mid-GAP -> all outputs 0 next cycle. start while intaking_configs=1 -> ignored (busy stays 0).

Source files
------------

// File: rtl/aline_scheduler_pkg.sv
// Shared definitions for the A-line acquisition scheduler.
// Holds the FSM state encoding, the state width and the A-line count limit,
// plus a helper that clamps the requested A-line count to what the config
// store can hold.
package aline_scheduler_pkg;

  localparam int unsigned STATE_W    = 4;
  localparam int unsigned MAX_ALINES = 16;

  typedef enum logic [STATE_W-1:0] {
    SCHED_IDLE    = 4'd0,
    SCHED_REQ     = 4'd1,
    SCHED_WAIT_HI = 4'd2,
    SCHED_WAIT_LO = 4'd3,
    SCHED_SETTLE  = 4'd4,
    SCHED_FIRE    = 4'd5,
    SCHED_ACQ     = 4'd6,
    SCHED_GAP     = 4'd7,
    SCHED_DONE    = 4'd8,
    SCHED_ERR     = 4'd9
  } sched_state_e;

  // Requests for more A-lines than are stored collapse to the full set.
  function automatic logic [4:0] clamp_alines(input logic [4:0] sel);
    if (sel > 5'(MAX_ALINES)) begin
      return 5'(MAX_ALINES);
    end
    return sel;
  endfunction

endpackage

// File: rtl/aline_scheduler_sched_timer.sv
// Saturating cycle counter shared by the settle, timeout and PRI waits.
// Ports:
//   clk, rst   - clock and synchronous active-low reset
//   clr        - force the count to zero (highest priority)
//   load       - load load_val into the count
//   load_val   - value loaded when load is high
//   en         - count up by one; holds at all-ones instead of wrapping
//   term       - terminal value of the current wait
//   tc         - high once count >= term-1 (always high when term is 0)
module aline_scheduler_sched_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A count of 0..term-1 spans exactly term cycles of the waiting state.
  assign tc = (term == '0) || (count >= (term - CNT_W'(1)));

endmodule

// File: rtl/aline_scheduler.sv
// A-line acquisition scheduler. For each stored A-line it requests a delay
// readout from the config store, waits for the busy flag to rise and fall,
// lets the delay registers settle, fires the transmitter, waits for the
// acquisition and then holds off for the pulse repetition interval.
// Ports:
//   clk, rst          - clock and synchronous active-low reset
//   start             - one-cycle image request (dropped while configs load)
//   abort             - level; returns the scheduler to idle
//   intaking_configs  - config store is loading; also returns to idle
//   updating_delays   - config store delay-readout busy flag
//   aline_select      - number of A-lines in the image (clamped to 16)
//   channel_select    - enabled transmit channels, latched at start
//   acq_done          - acquisition of the current A-line finished
//   rd_en             - one-cycle delay-read request
//   which_aline       - A-line index being read and fired
//   fire              - one-cycle transmit strobe
//   fire_channels     - latched channel_select
//   busy              - image acquisition in progress
//   image_done        - one-cycle pulse after the last A-line
//   timeout_err       - sticky; set on a readout or acquisition timeout
module aline_scheduler
  import aline_scheduler_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned UPD_TIMEOUT   = 32,
  parameter int unsigned ACQ_TIMEOUT   = 50000,
  parameter int unsigned PRI_CYCLES    = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       intaking_configs,
  input  logic       updating_delays,
  input  logic [4:0] aline_select,
  input  logic [7:0] channel_select,
  input  logic       acq_done,
  output logic       rd_en,
  output logic [3:0] which_aline,
  output logic       fire,
  output logic [7:0] fire_channels,
  output logic       busy,
  output logic       image_done,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] UPD_TERM    = CNT_W'(UPD_TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ACQ_TERM    = CNT_W'(ACQ_TIMEOUT);
  localparam logic [CNT_W-1:0] PRI_TERM    = CNT_W'(PRI_CYCLES);

  sched_state_e     state;
  logic [4:0]       n_alines;
  logic [4:0]       n_sel;
  logic             last_aline;
  logic             override;
  logic [CNT_W-1:0] tmr_term;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;

  assign n_sel      = clamp_alines(aline_select);
  assign last_aline = ({1'b0, which_aline} == (n_alines - 5'd1));
  assign override   = abort | intaking_configs;

  // The timer runs only in waiting states and is cleared on the cycle a wait
  // completes, so the next waiting state always starts from zero.
  always_comb begin
    tmr_term = '0;
    tmr_en   = 1'b0;
    tmr_clr  = 1'b1;
    case (state)
      SCHED_WAIT_HI: begin
        tmr_term = UPD_TERM;
        tmr_en   = 1'b1;
        tmr_clr  = updating_delays;
      end
      SCHED_WAIT_LO: begin
        tmr_term = UPD_TERM;
        tmr_en   = 1'b1;
        tmr_clr  = ~updating_delays;
      end
      SCHED_SETTLE: begin
        tmr_term = SETTLE_TERM;
        tmr_en   = 1'b1;
        tmr_clr  = tmr_tc;
      end
      SCHED_ACQ: begin
        tmr_term = ACQ_TERM;
        tmr_en   = 1'b1;
        tmr_clr  = acq_done;
      end
      SCHED_GAP: begin
        tmr_term = PRI_TERM;
        tmr_en   = 1'b1;
        tmr_clr  = tmr_tc;
      end
      default: begin
        tmr_term = '0;
        tmr_en   = 1'b0;
        tmr_clr  = 1'b1;
      end
    endcase
  end

  aline_scheduler_sched_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .load    (1'b0),
    .load_val({CNT_W{1'b0}}),
    .en      (tmr_en),
    .term    (tmr_term),
    .tc      (tmr_tc)
  );

  // Strobes are raised on the edge that enters their state so they are high
  // for exactly the cycle spent in that state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= SCHED_IDLE;
      n_alines      <= '0;
      rd_en         <= 1'b0;
      which_aline   <= '0;
      fire          <= 1'b0;
      fire_channels <= '0;
      busy          <= 1'b0;
      image_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      fire       <= 1'b0;
      image_done <= 1'b0;
      if ((state != SCHED_IDLE) && override) begin
        // Beats every other transition, including acq_done in the same cycle.
        state       <= SCHED_IDLE;
        busy        <= 1'b0;
        which_aline <= '0;
      end else begin
        case (state)
          SCHED_IDLE: begin
            if (start && !intaking_configs) begin
              n_alines      <= n_sel;
              fire_channels <= channel_select;
              timeout_err   <= 1'b0;
              which_aline   <= '0;
              busy          <= 1'b1;
              if (n_sel == 5'd0) begin
                state <= SCHED_DONE;
              end else begin
                state <= SCHED_REQ;
                rd_en <= 1'b1;
              end
            end
          end
          SCHED_REQ: begin
            state <= SCHED_WAIT_HI;
          end
          SCHED_WAIT_HI: begin
            if (updating_delays) begin
              state <= SCHED_WAIT_LO;
            end else if (tmr_tc) begin
              state       <= SCHED_ERR;
              timeout_err <= 1'b1;
              busy        <= 1'b0;
            end
          end
          SCHED_WAIT_LO: begin
            if (!updating_delays) begin
              state <= SCHED_SETTLE;
            end else if (tmr_tc) begin
              state       <= SCHED_ERR;
              timeout_err <= 1'b1;
              busy        <= 1'b0;
            end
          end
          SCHED_SETTLE: begin
            if (tmr_tc) begin
              state <= SCHED_FIRE;
              fire  <= 1'b1;
            end
          end
          SCHED_FIRE: begin
            state <= SCHED_ACQ;
          end
          SCHED_ACQ: begin
            if (acq_done) begin
              state <= SCHED_GAP;
            end else if (tmr_tc) begin
              state       <= SCHED_ERR;
              timeout_err <= 1'b1;
              busy        <= 1'b0;
            end
          end
          SCHED_GAP: begin
            if (tmr_tc) begin
              if (last_aline) begin
                state <= SCHED_DONE;
              end else begin
                which_aline <= which_aline + 4'd1;
                state       <= SCHED_REQ;
                rd_en       <= 1'b1;
              end
            end
          end
          SCHED_DONE: begin
            image_done  <= 1'b1;
            busy        <= 1'b0;
            which_aline <= '0;
            state       <= SCHED_IDLE;
          end
          SCHED_ERR: begin
            busy        <= 1'b0;
            which_aline <= '0;
            state       <= SCHED_IDLE;
          end
          default: begin
            state <= SCHED_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aline_scheduler.sv
// Scoreboard bench for aline_scheduler: stimulus pushes the expected rd_en,
// fire and image_done events into queues; a monitor pops and compares them
// whenever the scheduler presents one. A small config-store model raises
// updating_delays one cycle after rd_en for six cycles, and an acquisition
// model pulses acq_done twenty cycles after each fire.
module tb_aline_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       intaking_configs = 1'b0;
  logic       updating_delays = 1'b0;
  logic [4:0] aline_select = '0;
  logic [7:0] channel_select = '0;
  logic       acq_done = 1'b0;
  logic       rd_en;
  logic [3:0] which_aline;
  logic       fire;
  logic [7:0] fire_channels;
  logic       busy;
  logic       image_done;
  logic       timeout_err;

  aline_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .intaking_configs(intaking_configs),
    .updating_delays (updating_delays),
    .aline_select    (aline_select),
    .channel_select  (channel_select),
    .acq_done        (acq_done),
    .rd_en           (rd_en),
    .which_aline     (which_aline),
    .fire            (fire),
    .fire_channels   (fire_channels),
    .busy            (busy),
    .image_done      (image_done),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  bit store_en   = 1'b1;
  int abort_line = -1;

  typedef struct {
    int         line;
    logic [7:0] ch;
    int         at;   // expected cycle, or -1 when not timed
  } fire_exp_t;

  int        exp_rd[$];
  fire_exp_t exp_fire[$];
  int        exp_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: strobe seen at cycle %0d, required none", name, cyc);
  endtask

  // Monitor: compares every strobe against the scoreboard.
  initial begin
    fire_exp_t fe;
    int        de;
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1) begin
        if (exp_rd.size() == 0) unexpected("rd_en_unexpected");
        else check("rd_which_aline", 32'(which_aline), exp_rd.pop_front());
      end
      if (fire === 1'b1) begin
        if (exp_fire.size() == 0) unexpected("fire_unexpected");
        else begin
          fe = exp_fire.pop_front();
          check("fire_which_aline", 32'(which_aline), fe.line);
          check("fire_channels", 32'(fire_channels), 32'(fe.ch));
          if (fe.at >= 0) check("fire_cycle", cyc, fe.at);
        end
      end
      if (image_done === 1'b1) begin
        if (exp_done.size() == 0) unexpected("image_done_unexpected");
        else begin
          de = exp_done.pop_front();
          if (de >= 0) check("image_done_cycle", cyc, de);
          check("image_done_busy", 32'(busy), 0);
        end
      end
    end
  end

  // Config-store model.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1 && store_en) begin
        @(posedge clk);
        #1 updating_delays = 1'b1;
        repeat (6) @(posedge clk);
        #1 updating_delays = 1'b0;
      end
    end
  end

  // Acquisition model; optionally raises abort together with acq_done.
  initial begin
    int line;
    forever begin
      @(negedge clk);
      if (fire === 1'b1) begin
        line = int'(which_aline);
        repeat (20) @(posedge clk);
        #1 acq_done = 1'b1;
        if (line == abort_line) abort = 1'b1;
        @(posedge clk);
        #1 acq_done = 1'b0;
        abort = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [4:0] sel, input logic [7:0] ch, output int t0);
    @(posedge clk);
    #1 aline_select = sel;
    channel_select = ch;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 0);
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check({name, "_rd_pending"}, exp_rd.size(), 0);
    check({name, "_fire_pending"}, exp_fire.size(), 0);
    check({name, "_done_pending"}, exp_done.size(), 0);
    exp_rd.delete();
    exp_fire.delete();
    exp_done.delete();
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({rd_en, which_aline, fire, fire_channels, busy, image_done, timeout_err});
  endfunction

  initial begin
    int t0;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: three A-lines
    do_start(5'd3, 8'hA5, t0);
    for (int i = 0; i < 3; i++) begin
      exp_rd.push_back(i);
      exp_fire.push_back('{line: i, ch: 8'hA5, at: (i == 0) ? t0 + 13 : -1});
    end
    exp_done.push_back(-1);
    wait_idle("t1_idle", 6000);
    drain("t1");
    check("t1_timeout_err", 32'(timeout_err), 0);
    check("t1_which_aline_after", 32'(which_aline), 0);

    // 2: zero A-lines
    do_start(5'd0, 8'h3C, t0);
    exp_done.push_back(t0 + 2);
    wait_idle("t2_idle", 100);
    drain("t2");

    // 3: 20 requested clamps to 16
    do_start(5'd20, 8'h81, t0);
    for (int i = 0; i < 16; i++) begin
      exp_rd.push_back(i);
      exp_fire.push_back('{line: i, ch: 8'h81, at: -1});
    end
    exp_done.push_back(-1);
    wait_idle("t3_idle", 20000);
    drain("t3");
    check("t3_which_aline_after", 32'(which_aline), 0);

    // 4: readout never starts -> timeout
    store_en = 1'b0;
    do_start(5'd3, 8'h0F, t0);
    exp_rd.push_back(0);
    while (cyc < t0 + 33) @(negedge clk);
    check("t4_err_before_timeout", 32'(timeout_err), 0);
    @(negedge clk);
    check("t4_timeout_err", 32'(timeout_err), 1);
    check("t4_busy", 32'(busy), 0);
    drain("t4");
    check("t4_err_sticky", 32'(timeout_err), 1);
    store_en = 1'b1;

    // 4b: next start clears the error
    do_start(5'd0, 8'h55, t0);
    check("t4b_err_cleared", 32'(timeout_err), 0);
    exp_done.push_back(t0 + 2);
    wait_idle("t4b_idle", 100);
    drain("t4b");

    // 5: abort together with acq_done on A-line 1
    abort_line = 1;
    do_start(5'd3, 8'hC3, t0);
    for (int i = 0; i < 2; i++) begin
      exp_rd.push_back(i);
      exp_fire.push_back('{line: i, ch: 8'hC3, at: -1});
    end
    n = 0;
    while (abort !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t5_abort_reached", 32'(abort), 1);
    @(negedge clk);
    check("t5_busy_dropped", 32'(busy), 0);
    check("t5_no_image_done", 32'(image_done), 0);
    abort_line = -1;
    repeat (1100) @(negedge clk);
    drain("t5");
    check("t5_busy_after", 32'(busy), 0);

    // 6: reset in the middle of GAP
    do_start(5'd2, 8'h99, t0);
    exp_rd.push_back(0);
    exp_fire.push_back('{line: 0, ch: 8'h99, at: t0 + 13});
    n = 0;
    while (acq_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_acq_reached", 32'(acq_done), 1);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_reset_outputs", all_outputs(), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (1100) @(negedge clk);
    drain("t6");

    // 6b: start while configs are loading is dropped
    @(posedge clk);
    #1 intaking_configs = 1'b1;
    aline_select = 5'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6b_busy_while_intaking", 32'(busy), 0);
    @(posedge clk);
    #1 intaking_configs = 1'b0;
    repeat (50) @(negedge clk);
    drain("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
